// File: rtl/scmp_led_pkg.sv
// Shared types for the SC/MP address LED display: scan states and mode codes.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package scmp_led_pkg;

    typedef enum logic [1:0] {
        S_HI  = 2'd0,
        S_MID = 2'd1,
        S_LO  = 2'd2,
        S_GAP = 2'd3
    } scan_state_t;

    // The mode codes double as nibble-select codes for sel.
    localparam logic [1:0] MODE_HI   = 2'b00;
    localparam logic [1:0] MODE_MID  = 2'b01;
    localparam logic [1:0] MODE_LO   = 2'b10;
    localparam logic [1:0] MODE_SCAN = 2'b11;

    // Auto-scan order: HI -> MID -> LO -> blank gap -> HI.
    function automatic scan_state_t scan_next(input scan_state_t s);
        case (s)
            S_HI:    return S_MID;
            S_MID:   return S_LO;
            S_LO:    return S_GAP;
            default: return S_HI;
        endcase
    endfunction

endpackage

// File: rtl/scmp_led_chan.sv
// One LED channel: activity stretch counter plus dim PWM compare, producing a lit flag.
// Latency: act_cnt loads on the strobe edge; lit is combinational from registered state.
// Backpressure: none; a strobe is acted on in the cycle it is high.
module scmp_led_chan
    import scmp_led_pkg::*;
#(
    parameter int ACT_W    = 20,
    parameter int PWM_W    = 4,
    parameter int DIM_DUTY = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stb,
    input  logic             bit_new,
    input  logic             bit_old,
    input  logic [PWM_W-1:0] pwm_cnt,
    output logic             lit
);

    // One extra bit so a duty of 2**PWM_W (always on) is representable.
    localparam logic [PWM_W:0] DUTY = (PWM_W+1)'(DIM_DUTY);

    logic [ACT_W-1:0] act_cnt;

    // Reload the stretch when the sampled bit toggles, otherwise count down to zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_cnt <= '0;
        end else if (stb && (bit_new != bit_old)) begin
            act_cnt <= '1;
        end else if (act_cnt != '0) begin
            act_cnt <= act_cnt - 1'b1;
        end
    end

    // Full brightness while stretched; steady ones glow dimly at the PWM duty.
    always_comb begin
        lit = (act_cnt != '0) || (bit_old && ({1'b0, pwm_cnt} < DUTY));
    end

endmodule

// File: rtl/scmp_led_disp.sv
// SC/MP address display: latches the address on addr_stb and shows one nibble (fixed or auto-scanned) on active-low LEDs.
// Latency: addr_stb at edge N updates addr_q at N and led_n at N+1.
// Backpressure: none; addr_stb is sampled every cycle it is high.
module scmp_led_disp
    import scmp_led_pkg::*;
#(
    parameter int ADDR_W   = 12,   // must equal 3*LED_N
    parameter int LED_N    = 4,
    parameter int HOLD_W   = 24,
    parameter int ACT_W    = 20,
    parameter int PWM_W    = 4,
    parameter int DIM_DUTY = 3
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    input  logic              addr_stb,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        mode,
    output logic [LED_N-1:0]  led_n
);

    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        sel;
    logic [1:0]        sel_nxt;
    scan_state_t       state;
    scan_state_t       state_nxt;
    logic [HOLD_W-1:0] timer;
    logic [HOLD_W-1:0] timer_nxt;
    logic              scan_q;      // mode was auto-scan last cycle
    logic [PWM_W-1:0]  pwm_cnt;
    logic              blank;
    logic [LED_N-1:0]  nib_new;
    logic [LED_N-1:0]  nib_old;
    logic [LED_N-1:0]  lit;

    // Select code 3 (gap) falls back to the LO nibble; the LEDs are blanked then anyway.
    function automatic logic [LED_N-1:0] pick(input logic [ADDR_W-1:0] a, input logic [1:0] s);
        case (s)
            MODE_HI:  return a[3*LED_N-1 -: LED_N];
            MODE_MID: return a[2*LED_N-1 -: LED_N];
            default:  return a[LED_N-1:0];
        endcase
    endfunction

    // Scan state register with dwell timer; scan_q detects entry into auto-scan.
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            state  <= S_HI;
            timer  <= '0;
            scan_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            timer  <= timer_nxt;
            scan_q <= (mode == MODE_SCAN);
        end
    end

    // Next scan state: frozen at HI/0 outside auto-scan and on the entry edge, else advance on timer wrap.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer + 1'b1;
        if ((mode != MODE_SCAN) || !scan_q) begin
            state_nxt = S_HI;
            timer_nxt = '0;
        end else if (timer == '1) begin
            state_nxt = scan_next(state);
        end
    end

    // Scan outputs: sel tracks the mode or the upcoming scan state; the gap state blanks.
    always_comb begin
        sel_nxt = mode;
        if (mode == MODE_SCAN) begin
            sel_nxt = state_nxt;
        end
        blank = (state == S_GAP);
    end

    // Address latch, registered nibble select and free-running PWM counter.
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            addr_q  <= '0;
            sel     <= MODE_HI;
            pwm_cnt <= '0;
        end else begin
            if (addr_stb) begin
                addr_q <= addr;
            end
            sel     <= sel_nxt;
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // Activity compare uses the sel in force this cycle, even when a scan advance lands on the same edge.
    always_comb begin
        nib_new = pick(addr, sel);
        nib_old = pick(addr_q, sel);
    end

    for (genvar i = 0; i < LED_N; i++) begin : g_chan
        scmp_led_chan #(
            .ACT_W    (ACT_W),
            .PWM_W    (PWM_W),
            .DIM_DUTY (DIM_DUTY)
        ) u_chan (
            .clk     (clk_50m),
            .rst_n   (rst_n),
            .stb     (addr_stb),
            .bit_new (nib_new[i]),
            .bit_old (nib_old[i]),
            .pwm_cnt (pwm_cnt),
            .lit     (lit[i])
        );
    end

    // Registered active-low LED drive, forced dark during the scan gap.
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            led_n <= '1;
        end else if (blank) begin
            led_n <= '1;
        end else begin
            led_n <= ~lit;
        end
    end

endmodule

// File: tb/tb_scmp_led_disp.sv
// Directed bench for scmp_led_disp with short timers (HOLD_W=3, ACT_W=3, PWM_W=2, DIM_DUTY=2).
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected LED patterns are hand-derived per window of cycles.
module tb_scmp_led_disp;

    logic        clk_50m;
    logic        rst_n;
    logic        addr_stb;
    logic [11:0] addr;
    logic [1:0]  mode;
    logic [3:0]  led_n;

    int n_checks;
    int n_fail;

    logic [3:0] obs_or;      // bits lit at least once in the window
    int         obs_cnt [4]; // per-bit count of lit samples in the window

    typedef struct {
        logic [1:0]  mode;
        logic        stb;
        logic [11:0] addr;
        int          n;
        logic [3:0]  al;   // bits lit on every sample
        logic [3:0]  hf;   // bits lit on exactly half the samples (dim)
    } vec_t;

    vec_t       vt [9];
    logic [3:0] scan_exp [5];

    scmp_led_disp #(
        .ADDR_W   (12),
        .LED_N    (4),
        .HOLD_W   (3),
        .ACT_W    (3),
        .PWM_W    (2),
        .DIM_DUTY (2)
    ) dut (
        .clk_50m  (clk_50m),
        .rst_n    (rst_n),
        .addr_stb (addr_stb),
        .addr     (addr),
        .mode     (mode),
        .led_n    (led_n)
    );

    initial clk_50m = 1'b0;
    always #5 clk_50m = ~clk_50m;

    task automatic cyc();
        @(posedge clk_50m);
        @(negedge clk_50m);
    endtask

    task automatic observe(input int n);
        obs_or = 4'h0;
        for (int b = 0; b < 4; b++) obs_cnt[b] = 0;
        for (int k = 0; k < n; k++) begin
            cyc();
            obs_or = obs_or | ~led_n;
            for (int b = 0; b < 4; b++) begin
                if (!led_n[b]) obs_cnt[b] = obs_cnt[b] + 1;
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks = n_checks + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic strobe(input logic [11:0] a);
        addr     = a;
        addr_stb = 1'b1;
        cyc();
        addr_stb = 1'b0;
    endtask

    task automatic enter_scan();
        mode = 2'b11;
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // mode, stb, addr, samples, always-lit, half-lit
        vt[0] = '{2'b00, 1'b0, 12'h000, 4, 4'h0, 4'h0};  // addr_q cleared by reset
        vt[1] = '{2'b00, 1'b1, 12'hA00, 7, 4'hA, 4'h0};  // toggles stretch bits 3,1
        vt[2] = '{2'b00, 1'b1, 12'hA00, 8, 4'h0, 4'hA};  // same value: dim only
        vt[3] = '{2'b10, 1'b0, 12'h000, 8, 4'h0, 4'h0};  // LO nibble of A00 is 0
        vt[4] = '{2'b10, 1'b1, 12'h000, 8, 4'h0, 4'h0};  // no LO change
        vt[5] = '{2'b10, 1'b1, 12'h005, 7, 4'h5, 4'h0};  // bits 0,2 stretched
        vt[6] = '{2'b10, 1'b0, 12'h000, 8, 4'h0, 4'h5};  // back to dim
        vt[7] = '{2'b10, 1'b1, 12'h000, 7, 4'h5, 4'h0};  // toggled to 0 still lit
        vt[8] = '{2'b10, 1'b0, 12'h000, 8, 4'h0, 4'h0};  // all dark

        scan_exp[0] = 4'h1;
        scan_exp[1] = 4'h2;
        scan_exp[2] = 4'h3;
        scan_exp[3] = 4'h0;
        scan_exp[4] = 4'h1;

        // Reset held with a concurrent strobe: reset wins, LEDs stay dark.
        rst_n    = 1'b0;
        addr_stb = 1'b1;
        addr     = 12'hFFF;
        mode     = 2'b00;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check($sformatf("reset led_n cycle %0d", k), int'(led_n), 15);
        end
        rst_n    = 1'b1;
        addr_stb = 1'b0;

        // Fixed-mode vectors.
        for (int r = 0; r < 9; r++) begin
            mode     = vt[r].mode;
            addr     = vt[r].addr;
            addr_stb = vt[r].stb;
            cyc();
            addr_stb = 1'b0;
            observe(vt[r].n);
            for (int b = 0; b < 4; b++) begin
                int e;
                e = vt[r].al[b] ? vt[r].n : (vt[r].hf[b] ? vt[r].n / 2 : 0);
                check($sformatf("vec%0d led%0d lit count", r, b), obs_cnt[b], e);
            end
        end

        // Auto-scan of 12'h123: 1, 2, 3, gap, 1 with 8 cycles per phase.
        mode = 2'b00;
        strobe(12'h123);
        repeat (10) cyc();
        enter_scan();
        for (int p = 0; p < 5; p++) begin
            observe(8);
            check($sformatf("scan phase %0d nibble", p), int'(obs_or), int'(scan_exp[p]));
        end

        // Leave scan in the middle of LO for fixed MID.
        mode = 2'b00;
        repeat (2) cyc();
        enter_scan();
        observe(16);
        observe(4);
        check("mid-LO nibble before switch", int'(obs_or), 3);
        mode = 2'b01;
        cyc();
        observe(4);
        check("nibble after switch to MID", int'(obs_or), 2);

        // Strobe on the HI->MID advance edge: HI-only change stretches bit 3.
        mode = 2'b00;
        repeat (2) cyc();
        enter_scan();
        repeat (7) cyc();
        strobe(12'h923);
        observe(7);
        check("coincide HI change bit3 lit", obs_cnt[3], 7);
        check("coincide HI change bit2 lit", obs_cnt[2], 0);

        // Same edge, MID-only change: no stretch, bit 3 only dim from MID nibble A.
        mode = 2'b00;
        repeat (10) cyc();
        enter_scan();
        repeat (7) cyc();
        strobe(12'h9A3);
        observe(8);
        check("coincide MID change bit3 lit", obs_cnt[3], 4);

        // Reset during a stretch while scanning LO.
        mode = 2'b00;
        strobe(12'h923);
        repeat (10) cyc();
        enter_scan();
        repeat (16) cyc();
        strobe(12'h920);
        cyc();
        cyc();
        check("stretch active before reset", int'(led_n[1:0]), 0);
        rst_n = 1'b0;
        cyc();
        check("led_n on reset edge", int'(led_n), 15);
        rst_n = 1'b1;
        observe(3);
        check("dark after reset", int'(obs_or), 0);
        strobe(12'hFFF);
        observe(13);
        observe(8);
        check("post-reset LO phase", int'(obs_or), 15);
        observe(8);
        check("post-reset gap phase", int'(obs_or), 0);
        observe(8);
        check("post-reset HI phase", int'(obs_or), 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
